// File: rtl/frogger_pkg.sv
// Shared types and constants for the frogger d-pad path: direction indices,
// the packed d-pad type, the conditioner FSM states and small helpers.
package frogger_pkg;

    // Bit positions within a packed d-pad word {right, up, down, left}.
    localparam int DIR_LEFT  = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_RIGHT = 3;

    typedef logic [3:0] dpad_t;

    typedef enum logic {
        IDLE,
        COOLDOWN
    } dpad_state_t;

    // Width of a counter that must hold the values 0 .. n-1 (at least 1 bit).
    function automatic int cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reduce simultaneous press events to a single direction:
    // up > down > left > right. Losers are simply discarded.
    function automatic dpad_t arbitrate(input dpad_t ev);
        dpad_t win;
        win = '0;
        if (ev[DIR_UP])
            win[DIR_UP] = 1'b1;
        else if (ev[DIR_DOWN])
            win[DIR_DOWN] = 1'b1;
        else if (ev[DIR_LEFT])
            win[DIR_LEFT] = 1'b1;
        else if (ev[DIR_RIGHT])
            win[DIR_RIGHT] = 1'b1;
        return win;
    endfunction

endpackage

// File: rtl/dpad_conditioner_if.sv
// Button-side bundle of the d-pad conditioner: raw pins and enable in,
// move strobes, jump-sound strobes and debounced levels out.
interface dpad_conditioner_if;
    import frogger_pkg::*;

    dpad_t buttons_raw;
    logic  enable;
    dpad_t move;
    logic  jump_forward;
    logic  jump_backward;
    logic  jump_left;
    logic  jump_right;
    dpad_t held;

    modport master (
        output buttons_raw, enable,
        input  move, jump_forward, jump_backward, jump_left, jump_right, held
    );

    modport slave (
        input  buttons_raw, enable,
        output move, jump_forward, jump_backward, jump_left, jump_right, held
    );

endinterface

// File: rtl/dpad_conditioner_debounce.sv
// Single-bit two-flop synchroniser followed by a debounce counter. The
// debounced level only flips after the synchronised input has disagreed with
// it for DEBOUNCE_CYCLES consecutive cycles.
module debounce
    import frogger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 251000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] cnt;

    // Synchronise the pin and accept a new level once it has been stable long enough.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the synchroniser flops are reset along with the counter so a
            // button held through reset is seen as a fresh 0->1 once debounced.
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values; blocking would collapse the two-flop chain.
            sync_q <= {sync_q[0], din};
            if (sync_q[1] == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpad_conditioner.sv
// D-pad conditioner: debounces the four raw buttons, turns rising edges of the
// debounced levels into single arbitrated one-cycle move strobes, enforces a
// post-move cooldown and optionally re-fires a held direction.
module dpad_conditioner
    import frogger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 251000,
    parameter int unsigned COOLDOWN_CYCLES = 2510000,
    parameter int unsigned REPEAT_CYCLES   = 0,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input logic               clk,
    input logic               reset_n,
    dpad_conditioner_if.slave bus
);

    localparam int CW = cnt_width(COOLDOWN_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam logic [CW-1:0] CD_LAST = CW'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
    localparam logic [RW-1:0] RP_LAST = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    dpad_t       held_lvl;
    dpad_t       held_prev;
    dpad_t       press;
    dpad_t       win;
    dpad_t       fire_dir;
    dpad_t       move_q,   move_n;
    dpad_t       last_dir, last_dir_n;
    dpad_state_t state,    state_n;
    logic [CW-1:0] cd_cnt,   cd_cnt_n;
    logic [RW-1:0] hold_cnt, hold_cnt_n;
    logic        armed,    armed_n;
    logic        held_last;
    logic        rp_hit;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (bus.buttons_raw[i] ^ ACTIVE_LOW),
            .level  (held_lvl[i])
        );
    end

    // Press events are rising edges of the debounced levels only.
    assign press     = held_lvl & ~held_prev;
    assign win       = arbitrate(press);
    // 'armed' means last_dir came from a strobe and has been held ever since.
    assign held_last = |(held_lvl & last_dir);
    assign rp_hit    = (REPEAT_CYCLES != 0) && armed && held_last && (hold_cnt == RP_LAST);

    // Next-state, strobe, cooldown and hold-to-repeat decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the branches below can leave a value unassigned (no latches).
        state_n    = state;
        cd_cnt_n   = cd_cnt;
        hold_cnt_n = hold_cnt;
        last_dir_n = last_dir;
        armed_n    = armed;
        move_n     = '0;
        fire_dir   = '0;

        if (state == IDLE) begin
            if (|win)
                fire_dir = win;
            else if (rp_hit)
                fire_dir = last_dir;
        end

        if (!bus.enable) begin
            state_n    = IDLE;
            cd_cnt_n   = '0;
            hold_cnt_n = '0;
            armed_n    = 1'b0;
        end else if (|fire_dir) begin
            move_n     = fire_dir;
            last_dir_n = fire_dir;
            armed_n    = 1'b1;
            hold_cnt_n = '0;
            cd_cnt_n   = '0;
            state_n    = (COOLDOWN_CYCLES == 0) ? IDLE : COOLDOWN;
        end else begin
            armed_n = armed && held_last;
            case (state)
                IDLE: begin
                    if (armed && held_last)
                        hold_cnt_n = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
                    else
                        hold_cnt_n = '0;
                end
                COOLDOWN: begin
                    hold_cnt_n = '0;
                    if (cd_cnt == CD_LAST) begin
                        state_n  = IDLE;
                        cd_cnt_n = '0;
                    end else begin
                        cd_cnt_n = cd_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    cd_cnt_n = '0;
                end
            endcase
        end
    end

    // State, counters and the registered strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cd_cnt    <= '0;
            hold_cnt  <= '0;
            last_dir  <= '0;
            armed     <= 1'b0;
            held_prev <= '0;
            move_q    <= '0;
        end else begin
            state     <= state_n;
            cd_cnt    <= cd_cnt_n;
            hold_cnt  <= hold_cnt_n;
            last_dir  <= last_dir_n;
            armed     <= armed_n;
            held_prev <= held_lvl;
            move_q    <= move_n;
        end
    end

    assign bus.move          = move_q;
    assign bus.jump_forward  = move_q[DIR_UP];
    assign bus.jump_backward = move_q[DIR_DOWN];
    assign bus.jump_left     = move_q[DIR_LEFT];
    assign bus.jump_right    = move_q[DIR_RIGHT];
    assign bus.held          = held_lvl;

endmodule

// File: doc/dpad_conditioner.md
# dpad_conditioner

Conditions the four raw d-pad buttons into clean one-cycle move strobes for the frog movement logic and the audio jump-sound inputs. It sits between the board button pins and both the `frog` block and `topAudio`, on the 25.1 MHz pixel clock. Each button is synchronised and debounced, then edge-detected. Simultaneous presses are arbitrated to a single direction. A post-move cooldown and an optional hold-to-repeat are applied.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 251000: consecutive cycles a synchronised level must differ from the debounced level before it is accepted (10 ms at 25.1 MHz); minimum 1.
- `COOLDOWN_CYCLES`, default 2510000: cycles after any strobe during which new presses are dropped (100 ms); 0 means no cooldown.
- `REPEAT_CYCLES`, default 0: hold time before a held button re-fires; 0 disables repeat.
- `ACTIVE_LOW`, default 0: 1 means a pressed button reads 0 at the pin.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: 25.1 MHz pixel clock.
- `reset_n` input 1: asynchronous active-low reset.
- `buttons_raw` input 4: raw pins packed as {right, up, down, left}.
- `enable` input 1: game accepts moves; when low, strobes are suppressed.
- `move` output 4: one-hot or zero move strobe, same packing as `buttons_raw`, high for exactly 1 cycle.
- `jump_forward` output 1: equals `move[2]` (up).
- `jump_backward` output 1: equals `move[1]` (down).
- `jump_left` output 1: equals `move[0]`.
- `jump_right` output 1: equals `move[3]`.
- `held` output 4: debounced levels, active-high, registered.

## Operation
- **Polarity:** inputs are XORed with `ACTIVE_LOW`, then passed through a 2-FF synchroniser per bit.
- **Debounce (per bit):**
  - The counter increments while the synchronised level differs from `held[i]` and clears when they are equal.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the level still differs, `held[i]` toggles on the next edge and the counter clears.
  - The counter saturates; it never wraps.
- **Press event:** a rising edge of `held[i]`. Falling edges generate nothing.
- **Arbitration:** when several press events occur in the same cycle, priority is up > down > left > right. Losing events are discarded, not queued.
- **FSM states:**
  - IDLE:
    - An accepted press event with `enable`=1 registers the `move` strobe, latches the direction in `last_dir`, and goes to COOLDOWN.
    - If `REPEAT_CYCLES`≠0, `held[last_dir]`=1 and the hold counter reaches `REPEAT_CYCLES-1`, it strobes `last_dir` again and goes to COOLDOWN.
  - COOLDOWN:
    - The counter runs for `COOLDOWN_CYCLES` cycles, then the FSM returns to IDLE.
    - Press events are dropped in this state.
    - With `COOLDOWN_CYCLES`=0 the FSM returns to IDLE immediately after the strobe cycle.
- **Hold counter:** clears on every strobe and whenever `held[last_dir]`=0, and saturates.
- **`enable`=0:** press events are dropped, the FSM stays in or returns to IDLE, and the hold counter is cleared. A button already held when `enable` rises does not fire until it is released and pressed again.
- **Reset:**
  - All outputs are 0, `held`=0, the FSM is in IDLE, all counters are 0, and the synchronisers are 0.
  - A mid-operation reset aborts cooldown and discards in-flight edges.
  - After reset, a button held throughout is treated as a fresh press once debounced.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency from a raw pin change sampled at edge 0:
  - The synchroniser output changes after edge 2.
  - `held` toggles after edge 2+`DEBOUNCE_CYCLES`.
  - `move` goes high after edge 3+`DEBOUNCE_CYCLES` and lasts for 1 cycle.
- Minimum spacing between strobes is 1+`COOLDOWN_CYCLES` cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no change.

## Structure
- Shared package `frogger_pkg`:
  - Direction index constants `DIR_LEFT`=0, `DIR_DOWN`=1, `DIR_UP`=2, `DIR_RIGHT`=3.
  - Typedef `dpad_t` for the 4-bit packed d-pad.
  - FSM enum `dpad_state_t` {IDLE, COOLDOWN}.
- One sub-module `debounce`: a single-bit synchroniser plus debounce counter, instantiated 4×, parameterised by `DEBOUNCE_CYCLES`.
- Arbitration, FSM, cooldown and repeat logic live in `dpad_conditioner`.

## Test plan
Unless stated otherwise, the bench uses `DEBOUNCE_CYCLES`=4, `COOLDOWN_CYCLES`=8, `REPEAT_CYCLES`=0 and `enable`=1.
- Reset then clean press of up (`buttons_raw`=4'b0100) held for 20 cycles -> `held`=4'b0100 after edge 6; `move`=4'b0100 for exactly 1 cycle after edge 7; `jump_forward`=1 in that same cycle only.
- Up pulse of 3 cycles, released, then a 3-cycle re-press -> `held` and `move` stay 0 throughout.
- Up and left rising in the same cycle -> a single `move`=4'b0100; no left strobe follows.
- Down strobe, then right pressed so its press event lands inside cooldown -> right is dropped; a new right press after cooldown -> `move`=4'b1000.
- `REPEAT_CYCLES`=16, left held for 60 cycles -> first strobe, then a re-strobe every 16 cycles of hold counting after the return to IDLE; nothing after release.
- Assert `reset_n`=0 for 1 cycle mid-cooldown while up is held -> all outputs 0 immediately; up strobes again 4+3 cycles after reset deasserts. Separately, with `enable`=0 during a press -> no strobe.
